teclado_cajero: RTL and testbench

Keypad/terminal front-end that drives the ATM controller's user-side inputs.
- Debounces raw keypad codes and emits PIN digits as Digito/Digito_STB.
- Converts decimal key entry to a binary Monto with a Monto_STB pulse, and drives Tipo_trans and Tarjeta_recibida.
- Consumes the controller's status outputs (PIN_incorrecto, Bloqueo, Balance_actualizado, Fondos_insuficientes) to sequence the user session.

---
 rtl/teclado_cajero.sv | 264 ++++++++++++++++++++++++++
 tb/tb_teclado_cajero.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/teclado_cajero.sv
// ATM keypad front-end: debounces keys, captures the PIN and amount, and sequences the session.
// Define RETIRO_MULTIPLO_100_EN to only accept withdrawals that are whole multiples of 100.
module teclado_cajero #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int MAX_DIGITOS     = 9,
  parameter int TIMEOUT_RES     = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Tarjeta_insertada,
  input  logic [3:0]  Tecla,
  input  logic        Tecla_presionada,
  input  logic        PIN_incorrecto,
  input  logic        Bloqueo,
  input  logic        Balance_actualizado,
  input  logic        Fondos_insuficientes,
  output logic        Tarjeta_recibida,
  output logic [3:0]  Digito,
  output logic        Digito_STB,
  output logic        Tipo_trans,
  output logic [31:0] Monto,
  output logic        Monto_STB,
  output logic        Error_entrada
);

  localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int NW = $clog2(MAX_DIGITOS + 1);
  localparam int TW = $clog2(TIMEOUT_RES + 1);

  localparam logic [3:0] K_ENTER    = 4'd10;
  localparam logic [3:0] K_CANCEL   = 4'd11;
  localparam logic [3:0] K_DEPOSITO = 4'd12;
  localparam logic [3:0] K_RETIRO   = 4'd13;

  typedef enum logic [2:0] {
    REPOSO, CAPTURA_PIN, VERIFICA, ESPERA_TIPO, CAPTURA_MONTO, ESPERA_RESULTADO, BLOQUEADO
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    tecla_prev_q, tecla_prev_d;
  logic          armado_q, armado_d;
  logic          tarjeta_prev_q;
  logic [1:0]    pin_cnt_q, pin_cnt_d;
  logic [31:0]   acc_q, acc_d;
  logic [NW-1:0] ndig_q, ndig_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tarjeta_recibida_q, tarjeta_recibida_d;
  logic [3:0]    digito_q, digito_d;
  logic          digito_stb_q, digito_stb_d;
  logic          tipo_trans_q, tipo_trans_d;
  logic [31:0]   monto_q, monto_d;
  logic          monto_stb_q, monto_stb_d;
  logic          error_entrada_q, error_entrada_d;
`ifdef RETIRO_MULTIPLO_100_EN
  logic [1:0]    ceros_q, ceros_d;
`endif

  logic        key_event, es_digito, tarjeta_sube, monto_ok;
  logic [31:0] acc_x10;

  // A press is accepted once per key-down, after the code has been stable long enough.
  always_comb begin
    deb_cnt_d    = '0;
    tecla_prev_d = Tecla;
    armado_d     = armado_q;
    key_event    = 1'b0;
    if (!Tecla_presionada) begin
      armado_d = 1'b1;
    end else begin
      if (deb_cnt_q != '0 && Tecla == tecla_prev_q)
        deb_cnt_d = (deb_cnt_q == DW'(DEBOUNCE_CICLOS)) ? deb_cnt_q : deb_cnt_q + 1'b1;
      else
        deb_cnt_d = DW'(1);
      if (armado_q && deb_cnt_d == DW'(DEBOUNCE_CICLOS)) begin
        key_event = (Tecla < 4'd14);
        armado_d  = 1'b0;
      end
    end
  end

  assign es_digito    = (Tecla <= 4'd9);
  assign tarjeta_sube = Tarjeta_insertada && !tarjeta_prev_q;
  assign acc_x10      = (acc_q << 3) + (acc_q << 1) + {28'd0, Tecla};

  always_comb begin
    estado_d           = estado_q;
    pin_cnt_d          = pin_cnt_q;
    acc_d              = acc_q;
    ndig_d             = ndig_q;
    timer_d            = timer_q;
    tarjeta_recibida_d = 1'b0;
    digito_d           = digito_q;
    digito_stb_d       = 1'b0;
    tipo_trans_d       = tipo_trans_q;
    monto_d            = monto_q;
    monto_stb_d        = 1'b0;
    error_entrada_d    = 1'b0;
    monto_ok           = (ndig_q != '0) && (acc_q != '0);
`ifdef RETIRO_MULTIPLO_100_EN
    ceros_d            = ceros_q;
    if (tipo_trans_q && !(ndig_q >= NW'(3) && ceros_q == 2'b11))
      monto_ok = 1'b0;
`endif

    if (Bloqueo) begin
      estado_d = BLOQUEADO;
    end else if (estado_q != REPOSO && estado_q != BLOQUEADO && !Tarjeta_insertada) begin
      estado_d  = REPOSO;
      pin_cnt_d = '0;
      acc_d     = '0;
      ndig_d    = '0;
      timer_d   = '0;
    end else begin
      case (estado_q)
        REPOSO: begin
          if (tarjeta_sube) begin
            tarjeta_recibida_d = 1'b1;
            pin_cnt_d          = '0;
            estado_d           = CAPTURA_PIN;
          end
        end
        CAPTURA_PIN: begin
          if (key_event) begin
            if (es_digito) begin
              digito_d     = Tecla;
              digito_stb_d = 1'b1;
              pin_cnt_d    = pin_cnt_q + 1'b1;
              if (pin_cnt_q == 2'd3) begin
                timer_d  = '0;
                estado_d = VERIFICA;
              end
            end else if (Tecla == K_CANCEL) begin
              pin_cnt_d = '0;
            end else begin
              error_entrada_d = 1'b1;
            end
          end
        end
        // The controller's verdict is valid two cycles after the last digit strobe.
        VERIFICA: begin
          if (timer_q == TW'(2)) begin
            timer_d  = '0;
            estado_d = PIN_incorrecto ? CAPTURA_PIN : ESPERA_TIPO;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ESPERA_TIPO: begin
          if (key_event) begin
            if (Tecla == K_DEPOSITO || Tecla == K_RETIRO) begin
              tipo_trans_d = (Tecla == K_RETIRO);
              acc_d        = '0;
              ndig_d       = '0;
              estado_d     = CAPTURA_MONTO;
            end else if (Tecla == K_CANCEL) begin
              estado_d = REPOSO;
            end else begin
              error_entrada_d = 1'b1;
            end
          end
        end
        CAPTURA_MONTO: begin
          if (key_event) begin
            if (es_digito) begin
              if (ndig_q == NW'(MAX_DIGITOS)) begin
                error_entrada_d = 1'b1;
              end else begin
                acc_d  = acc_x10;
                ndig_d = ndig_q + 1'b1;
`ifdef RETIRO_MULTIPLO_100_EN
                ceros_d = {ceros_q[0], (Tecla == 4'd0)};
`endif
              end
            end else if (Tecla == K_ENTER) begin
              if (monto_ok) begin
                monto_d     = acc_q;
                monto_stb_d = 1'b1;
                timer_d     = '0;
                estado_d    = ESPERA_RESULTADO;
              end else begin
                error_entrada_d = 1'b1;
                acc_d           = '0;
                ndig_d          = '0;
              end
            end else if (Tecla == K_CANCEL) begin
              acc_d    = '0;
              ndig_d   = '0;
              estado_d = ESPERA_TIPO;
            end else begin
              error_entrada_d = 1'b1;
            end
          end
        end
        ESPERA_RESULTADO: begin
          if (Balance_actualizado || Fondos_insuficientes || timer_q == TW'(TIMEOUT_RES - 1)) begin
            error_entrada_d = !(Balance_actualizado || Fondos_insuficientes);
            acc_d           = '0;
            ndig_d          = '0;
            timer_d         = '0;
            estado_d        = ESPERA_TIPO;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        BLOQUEADO: estado_d = BLOQUEADO;
        default:   estado_d = REPOSO;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      estado_q           <= REPOSO;
      deb_cnt_q          <= '0;
      tecla_prev_q       <= '0;
      armado_q           <= 1'b1;
      tarjeta_prev_q     <= 1'b0;
      pin_cnt_q          <= '0;
      acc_q              <= '0;
      ndig_q             <= '0;
      timer_q            <= '0;
      tarjeta_recibida_q <= 1'b0;
      digito_q           <= '0;
      digito_stb_q       <= 1'b0;
      tipo_trans_q       <= 1'b0;
      monto_q            <= '0;
      monto_stb_q        <= 1'b0;
      error_entrada_q    <= 1'b0;
`ifdef RETIRO_MULTIPLO_100_EN
      ceros_q            <= '0;
`endif
    end else begin
      estado_q           <= estado_d;
      deb_cnt_q          <= deb_cnt_d;
      tecla_prev_q       <= tecla_prev_d;
      armado_q           <= armado_d;
      tarjeta_prev_q     <= Tarjeta_insertada;
      pin_cnt_q          <= pin_cnt_d;
      acc_q              <= acc_d;
      ndig_q             <= ndig_d;
      timer_q            <= timer_d;
      tarjeta_recibida_q <= tarjeta_recibida_d;
      digito_q           <= digito_d;
      digito_stb_q       <= digito_stb_d;
      tipo_trans_q       <= tipo_trans_d;
      monto_q            <= monto_d;
      monto_stb_q        <= monto_stb_d;
      error_entrada_q    <= error_entrada_d;
`ifdef RETIRO_MULTIPLO_100_EN
      ceros_q            <= ceros_d;
`endif
    end
  end

  assign Tarjeta_recibida = tarjeta_recibida_q;
  assign Digito           = digito_q;
  assign Digito_STB       = digito_stb_q;
  assign Tipo_trans       = tipo_trans_q;
  assign Monto            = monto_q;
  assign Monto_STB        = monto_stb_q;
  assign Error_entrada    = error_entrada_q;

endmodule

// File: tb/tb_teclado_cajero.sv
// Directed self-checking bench for teclado_cajero: PIN entry, amounts, debounce, lockout and reset.
module tb_teclado_cajero;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tarjeta = 1'b0;
  logic [3:0]  tecla = 4'd0;
  logic        pres = 1'b0;
  logic        pin_inc = 1'b0;
  logic        bloqueo = 1'b0;
  logic        balance = 1'b0;
  logic        fondos = 1'b0;
  logic        tarjeta_recibida, digito_stb, tipo_trans, monto_stb, error_entrada;
  logic [3:0]  digito;
  logic [31:0] monto;

  int checks = 0;
  int failures = 0;
  int n_tr = 0, n_dstb = 0, n_mstb = 0, n_err = 0, n_overlap = 0, n_long = 0;
  logic prev_tr = 1'b0, prev_dstb = 1'b0, prev_mstb = 1'b0;
  int b_tr, b_dstb, b_mstb, b_err;

  teclado_cajero dut (
    .CLK(clk), .Reset(rst), .Tarjeta_insertada(tarjeta), .Tecla(tecla),
    .Tecla_presionada(pres), .PIN_incorrecto(pin_inc), .Bloqueo(bloqueo),
    .Balance_actualizado(balance), .Fondos_insuficientes(fondos),
    .Tarjeta_recibida(tarjeta_recibida), .Digito(digito), .Digito_STB(digito_stb),
    .Tipo_trans(tipo_trans), .Monto(monto), .Monto_STB(monto_stb), .Error_entrada(error_entrada)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled mid-cycle: counts strobes and flags overlaps or stretched pulses.
  always @(negedge clk) begin
    if (!rst) begin
      n_tr   <= n_tr + int'(tarjeta_recibida);
      n_dstb <= n_dstb + int'(digito_stb);
      n_mstb <= n_mstb + int'(monto_stb);
      n_err  <= n_err + int'(error_entrada);
      if (int'(tarjeta_recibida) + int'(digito_stb) + int'(monto_stb) > 1) n_overlap <= n_overlap + 1;
      if ((tarjeta_recibida && prev_tr) || (digito_stb && prev_dstb) || (monto_stb && prev_mstb))
        n_long <= n_long + 1;
    end
    prev_tr   <= tarjeta_recibida;
    prev_dstb <= digito_stb;
    prev_mstb <= monto_stb;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic snap();
    @(negedge clk);
    b_tr = n_tr; b_dstb = n_dstb; b_mstb = n_mstb; b_err = n_err;
  endtask

  task automatic applyStimulus(input logic [3:0] k);
    @(negedge clk);
    tecla = k;
    pres  = 1'b1;
    repeat (6) @(negedge clk);
    pres = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_status(input bit es_fondos);
    @(negedge clk);
    if (es_fondos) fondos = 1'b1; else balance = 1'b1;
    @(negedge clk);
    fondos  = 1'b0;
    balance = 1'b0;
    wait_cycles(2);
  endtask

  initial begin
    $display("[TB] start");
    wait_cycles(3);
    checkOutput("reset_tr", {31'd0, tarjeta_recibida}, 0);
    checkOutput("reset_digito", {28'd0, digito}, 0);
    checkOutput("reset_strobes", {29'd0, digito_stb, monto_stb, error_entrada}, 0);
    checkOutput("reset_tipo", {31'd0, tipo_trans}, 0);
    checkOutput("reset_monto", monto, 0);
    rst = 1'b0;
    wait_cycles(2);

    snap();
    tarjeta = 1'b1;
    wait_cycles(3);
    checkOutput("card_accept", n_tr - b_tr, 1);

    snap();
    applyStimulus(4'd1); checkOutput("pin_d1", {28'd0, digito}, 1);
    applyStimulus(4'd2); checkOutput("pin_d2", {28'd0, digito}, 2);
    applyStimulus(4'd3); checkOutput("pin_d3", {28'd0, digito}, 3);
    applyStimulus(4'd4); checkOutput("pin_d4", {28'd0, digito}, 4);
    checkOutput("pin_strobes", n_dstb - b_dstb, 4);
    wait_cycles(2);

    snap();
    applyStimulus(4'd13);
    applyStimulus(4'd2); applyStimulus(4'd5); applyStimulus(4'd0); applyStimulus(4'd0);
    applyStimulus(4'd10);
    checkOutput("retiro_tipo", {31'd0, tipo_trans}, 1);
    checkOutput("retiro_monto", monto, 2500);
    checkOutput("retiro_mstb", n_mstb - b_mstb, 1);
    pulse_status(1'b1);
    checkOutput("retiro_err", n_err - b_err, 0);

    snap();
    applyStimulus(4'd12);
    for (int i = 0; i < 10; i++) applyStimulus(4'd9);
    applyStimulus(4'd10);
    checkOutput("dep_max_err", n_err - b_err, 1);
    checkOutput("dep_max_monto", monto, 999999999);
    checkOutput("dep_max_tipo", {31'd0, tipo_trans}, 0);
    checkOutput("dep_max_mstb", n_mstb - b_mstb, 1);
    pulse_status(1'b0);

    snap();
    applyStimulus(4'd12); applyStimulus(4'd5); applyStimulus(4'd10);
    checkOutput("timeout_monto", monto, 5);
    wait_cycles(20);
    checkOutput("timeout_err", n_err - b_err, 1);

    snap();
    applyStimulus(4'd13);
    applyStimulus(4'd2); applyStimulus(4'd5); applyStimulus(4'd0); applyStimulus(4'd10);
`ifdef RETIRO_MULTIPLO_100_EN
    checkOutput("mult100_reject_err", n_err - b_err, 1);
    checkOutput("mult100_reject_mstb", n_mstb - b_mstb, 0);
    applyStimulus(4'd3); applyStimulus(4'd0); applyStimulus(4'd0); applyStimulus(4'd10);
    checkOutput("mult100_accept_monto", monto, 300);
    checkOutput("mult100_accept_mstb", n_mstb - b_mstb, 1);
`else
    checkOutput("retiro250_err", n_err - b_err, 0);
    checkOutput("retiro250_monto", monto, 250);
    checkOutput("retiro250_mstb", n_mstb - b_mstb, 1);
`endif
    pulse_status(1'b1);

    snap();
    applyStimulus(4'd12); applyStimulus(4'd10);
    checkOutput("enter_empty_err", n_err - b_err, 1);
    checkOutput("enter_empty_mstb", n_mstb - b_mstb, 0);
    applyStimulus(4'd11); applyStimulus(4'd11);
    snap();
    applyStimulus(4'd3);
    checkOutput("idle_key_ignored", (n_err - b_err) + (n_dstb - b_dstb), 0);

    snap();
    tarjeta = 1'b0;
    wait_cycles(2);
    tarjeta = 1'b1;
    wait_cycles(3);
    checkOutput("card_reinsert", n_tr - b_tr, 1);

    snap();
    tecla = 4'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pres = ((i / 2) % 2 == 0);
    end
    repeat (5) @(negedge clk);
    pres = 1'b0;
    wait_cycles(3);
    checkOutput("bounce_strobes", n_dstb - b_dstb, 1);
    checkOutput("bounce_digito", {28'd0, digito}, 7);

    snap();
    applyStimulus(4'd10);
    checkOutput("pin_bad_key_err", n_err - b_err, 1);
    applyStimulus(4'd11);
    snap();
    pin_inc = 1'b1;
    applyStimulus(4'd5); applyStimulus(4'd6); applyStimulus(4'd7); applyStimulus(4'd8);
    wait_cycles(2);
    pin_inc = 1'b0;
    checkOutput("pin_wrong_strobes", n_dstb - b_dstb, 4);
    snap();
    applyStimulus(4'd9);
    checkOutput("pin_retry_strobe", n_dstb - b_dstb, 1);
    checkOutput("pin_retry_err", n_err - b_err, 0);
    checkOutput("pin_retry_digito", {28'd0, digito}, 9);

    snap();
    @(negedge clk);
    bloqueo = 1'b1;
    wait_cycles(2);
    for (int i = 0; i < 6; i++) applyStimulus(4'(i + 1));
    tarjeta = 1'b0;
    wait_cycles(3);
    tarjeta = 1'b1;
    bloqueo = 1'b0;
    applyStimulus(4'd1); applyStimulus(4'd13);
    checkOutput("blocked_quiet",
                (n_tr - b_tr) + (n_dstb - b_dstb) + (n_mstb - b_mstb) + (n_err - b_err), 0);
    checkOutput("blocked_digito", {28'd0, digito}, 9);

    @(negedge clk);
    rst = 1'b1;
    wait_cycles(2);
    checkOutput("rst2_digito", {28'd0, digito}, 0);
    checkOutput("rst2_monto", monto, 0);
    snap();
    rst = 1'b0;
    wait_cycles(3);
    checkOutput("rst2_card_accept", n_tr - b_tr, 1);

    checkOutput("strobe_overlap", n_overlap, 0);
    checkOutput("strobe_width", n_long, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
